// File: rtl/fft_stage_sequencer_if.sv
// Butterfly operand bus between the FFT stage sequencer (master) and the
// butterfly datapath (slave): operand/twiddle addresses with a valid/ready handshake.
interface fft_stage_sequencer_if #(
  parameter int N_LOG2 = 4
);
  logic              bfly_valid;
  logic              bfly_ready;
  logic [N_LOG2-1:0] addr_a;
  logic [N_LOG2-1:0] addr_b;
  logic [N_LOG2-2:0] tw_addr;

  modport master (
    output bfly_valid,
    output addr_a,
    output addr_b,
    output tw_addr,
    input  bfly_ready
  );

  modport slave (
    input  bfly_valid,
    input  addr_a,
    input  addr_b,
    input  tw_addr,
    output bfly_ready
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT stage controller: walks N/2 butterflies per stage, strobes the stage
// counter once per stage and reports fft_done after stage_done. Define STAGE_GAP_EN for an idle gap between stages.
module fft_stage_sequencer #(
  parameter int N_LOG2     = 4,
  parameter int GAP_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start,
  input  logic                  stage_done,
  output logic                  busy,
  output logic                  stage_strobe,
  output logic [3:0]            stage_idx,
  output logic                  fft_done,
  fft_stage_sequencer_if.master bfly
);

  if (N_LOG2 < 2 || N_LOG2 > 15) begin : g_bad_n_log2
    $error("fft_stage_sequencer: N_LOG2 must be in 2..15");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap_cycles
    $error("fft_stage_sequencer: GAP_CYCLES must be in 1..15");
  end

  localparam int              KW         = N_LOG2 - 1;
  localparam logic [KW-1:0]   K_LAST     = '1;
  localparam logic [KW-1:0]   K_ONE      = KW'(1);
  localparam logic [N_LOG2-1:0] A_ONE    = N_LOG2'(1);
  localparam logic [3:0]      LAST_STAGE = 4'(N_LOG2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    STROBE,
    WAIT_DONE,
    FINISH
`ifdef STAGE_GAP_EN
    , GAP
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    stage_q, stage_d;
  logic          seen_q, seen_d;
  logic          valid;

`ifdef STAGE_GAP_EN
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
  logic [3:0] gap_q, gap_d;
`endif

  // Operand addressing: span = 1<<s, pos = k mod span, grp = k / span.
  logic [N_LOG2-1:0] k_ext, span, pos, grp, base_a;
  logic [N_LOG2-2:0] tw_full;
  logic [4:0]        sh_a;
  logic [3:0]        sh_tw;

  always_comb begin
    k_ext   = {1'b0, k_q};
    span    = A_ONE << stage_q;
    pos     = k_ext & (span - A_ONE);
    grp     = k_ext >> stage_q;
    sh_a    = {1'b0, stage_q} + 5'd1;
    base_a  = (grp << sh_a) | pos;
    sh_tw   = LAST_STAGE - stage_q;
    tw_full = pos[N_LOG2-2:0] << sh_tw;
  end

  // Addresses are forced to zero outside ISSUE so every output is 0 in reset/IDLE.
  assign bfly.bfly_valid = valid;
  assign bfly.addr_a     = valid ? base_a        : '0;
  assign bfly.addr_b     = valid ? base_a + span : '0;
  assign bfly.tw_addr    = valid ? tw_full       : '0;
  assign stage_idx       = stage_q;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    stage_d      = stage_q;
    seen_d       = seen_q;
`ifdef STAGE_GAP_EN
    gap_d        = gap_q;
`endif
    busy         = 1'b1;
    valid        = 1'b0;
    stage_strobe = 1'b0;
    fft_done     = 1'b0;

    case (state_q)
      IDLE: begin
        busy   = 1'b0;
        seen_d = 1'b0;
        if (start) begin
          state_d = ISSUE;
          k_d     = '0;
          stage_d = '0;
        end
      end

      ISSUE: begin
        valid = 1'b1;
        if (stage_done) seen_d = 1'b1;
        if (bfly.bfly_ready) begin
          k_d = k_q + K_ONE;
          if (k_q == K_LAST) state_d = STROBE;
        end
      end

      STROBE: begin
        stage_strobe = 1'b1;
        if (stage_done) seen_d = 1'b1;
        if (stage_q != LAST_STAGE) begin
          stage_d = stage_q + 4'd1;
`ifdef STAGE_GAP_EN
          state_d = GAP;
          gap_d   = GAP_LOAD;
`else
          state_d = ISSUE;
`endif
        end else begin
          state_d = WAIT_DONE;
        end
      end

`ifdef STAGE_GAP_EN
      GAP: begin
        if (stage_done) seen_d = 1'b1;
        if (gap_q == 4'd0) state_d = ISSUE;
        else               gap_d   = gap_q - 4'd1;
      end
`endif

      WAIT_DONE: begin
        if (stage_done || seen_q) state_d = FINISH;
      end

      FINISH: begin
        fft_done = 1'b1;
        state_d  = IDLE;
        stage_d  = '0;
        k_d      = '0;
        seen_d   = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      seen_q  <= 1'b0;
`ifdef STAGE_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      seen_q  <= seen_d;
`ifdef STAGE_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: one N_LOG2=3 and one N_LOG2=4 instance,
// checking addressing, stalls, strobes, stage_done handling, reset abort and latency.
module tb_fft_stage_sequencer;

  localparam int GAP = 3;
`ifdef STAGE_GAP_EN
  localparam int GAP_LOW = 1 + GAP;
`else
  localparam int GAP_LOW = 1;
`endif

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic       n_reset;
  logic       start3, sdone3, busy3, strobe3, fdone3;
  logic [3:0] idx3;
  logic       start4, sdone4, busy4, strobe4, fdone4;
  logic [3:0] idx4;

  fft_stage_sequencer_if #(.N_LOG2(3)) bus3 ();
  fft_stage_sequencer_if #(.N_LOG2(4)) bus4 ();

  fft_stage_sequencer #(.N_LOG2(3), .GAP_CYCLES(GAP)) u_dut3 (
    .clk(tb_clk), .n_reset(n_reset), .start(start3), .stage_done(sdone3),
    .busy(busy3), .stage_strobe(strobe3), .stage_idx(idx3), .fft_done(fdone3),
    .bfly(bus3.master)
  );

  fft_stage_sequencer #(.N_LOG2(4), .GAP_CYCLES(GAP)) u_dut4 (
    .clk(tb_clk), .n_reset(n_reset), .start(start4), .stage_done(sdone4),
    .busy(busy4), .stage_strobe(strobe4), .stage_idx(idx4), .fft_done(fdone4),
    .bfly(bus4.master)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  // Hand-computed (a, b, tw) for N=8, stages 0..2, k=0..3.
  int exp_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int exp_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  int hs, st, lat, low, cyc, strobe_cyc;
  bit pulsed;

  initial begin
    n_reset = 1'b0;
    start3 = 1'b0; sdone3 = 1'b0; bus3.bfly_ready = 1'b0;
    start4 = 1'b0; sdone4 = 1'b0; bus4.bfly_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst4_outputs", 32'({busy4, strobe4, idx4, fdone4, bus4.bfly_valid,
                               bus4.addr_a, bus4.addr_b, bus4.tw_addr}), 0);
    check("rst3_outputs", 32'({busy3, strobe3, idx3, fdone3, bus3.bfly_valid,
                               bus3.addr_a, bus3.addr_b, bus3.tw_addr}), 0);
    n_reset = 1'b1;
    step();

    // Reset mid-ISSUE at k=3 (N=16)
    start4 = 1'b1; bus4.bfly_ready = 1'b1;
    step();
    start4 = 1'b0;
    repeat (3) step();
    check("a4_k3_valid", 32'(bus4.bfly_valid), 1);
    check("a4_k3_addr_a", 32'(bus4.addr_a), 6);
    check("a4_k3_addr_b", 32'(bus4.addr_b), 7);
    n_reset = 1'b0;
    step();
    check("a4_abort_outputs", 32'({busy4, strobe4, idx4, fdone4, bus4.bfly_valid,
                                   bus4.addr_a, bus4.addr_b, bus4.tw_addr}), 0);
    n_reset = 1'b1;
    step();

    // Fresh transform, stage_done already high so WAIT_DONE lasts one cycle
    start4 = 1'b1; sdone4 = 1'b1;
    hs = 0; st = 0;
    step();
    lat = 1;
    start4 = 1'b0;
    while (!fdone4 && lat < 400) begin
      if (bus4.bfly_valid && bus4.bfly_ready) hs++;
      if (strobe4) st++;
      step();
      lat++;
    end
    check("a4_done_seen", 32'(fdone4), 1);
    check("a4_handshakes", 32'(hs), 32);
    check("a4_strobes", 32'(st), 4);
    check("a4_latency", 32'(lat), 38 + 3 * (GAP_LOW - 1));
    sdone4 = 1'b0;
    step();
    check("a4_idle_busy", 32'({busy4, fdone4}), 0);

    // Address tables for N=8, with a 5-cycle stall at stage 1, k=2
    start3 = 1'b1; bus3.bfly_ready = 1'b1;
    step();
    start3 = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) begin
        if (s == 1 && k == 2) begin
          bus3.bfly_ready = 1'b0;
          for (int c = 0; c < 5; c++) begin
            step();
            check("b3_stall_hold", 32'({bus3.bfly_valid, bus3.addr_a, bus3.addr_b, strobe3}),
                  32'({1'b1, 3'd4, 3'd6, 1'b0}));
          end
          bus3.bfly_ready = 1'b1;
        end
        check("b3_valid", 32'(bus3.bfly_valid), 1);
        check("b3_addr_a", 32'(bus3.addr_a), exp_a[s*4+k]);
        check("b3_addr_b", 32'(bus3.addr_b), exp_b[s*4+k]);
        check("b3_tw_addr", 32'(bus3.tw_addr), exp_tw[s*4+k]);
        check("b3_stage_idx", 32'(idx3), s);
        step();
      end
      check("b3_strobe", 32'({strobe3, bus3.bfly_valid}), 32'({1'b1, 1'b0}));
      check("b3_strobe_idx", 32'(idx3), s);
      if (s < 2) begin
        low = 1;
        step();
        while (!bus3.bfly_valid && low < 20) begin
          check("b3_gap_no_strobe", 32'(strobe3), 0);
          low++;
          step();
        end
        check("b3_valid_low_len", 32'(low), GAP_LOW);
      end
    end

    // stage_done arrives late: busy held, fft_done only after it is sampled
    step();
    for (int c = 0; c < 20; c++) begin
      check("b3_wait_busy", 32'({busy3, fdone3}), 32'({1'b1, 1'b0}));
      step();
    end
    sdone3 = 1'b1;
    step();
    check("b3_finish", 32'({busy3, fdone3}), 32'({1'b1, 1'b1}));
    sdone3 = 1'b0;
    step();
    check("b3_idle", 32'({busy3, fdone3, idx3}), 0);

    // stage_done pulsed during stage 1 (and a stray start): flag lets WAIT_DONE exit in one cycle
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    hs = 0; st = 0; cyc = 0; strobe_cyc = 0; pulsed = 1'b0;
    while (!fdone3 && cyc < 200) begin
      if (bus3.bfly_valid && bus3.bfly_ready) hs++;
      if (strobe3) begin
        st++;
        strobe_cyc = cyc;
      end
      if (st == 1 && !pulsed && bus3.bfly_valid) begin
        sdone3 = 1'b1; start3 = 1'b1; pulsed = 1'b1;
      end else begin
        sdone3 = 1'b0; start3 = 1'b0;
      end
      step();
      cyc++;
    end
    sdone3 = 1'b0; start3 = 1'b0;
    check("c3_done_seen", 32'(fdone3), 1);
    check("c3_handshakes", 32'(hs), 12);
    check("c3_strobes", 32'(st), 3);
    check("c3_strobe_to_done", 32'(cyc - strobe_cyc), 2);
    step();
    check("c3_idle_busy", 32'(busy3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
